// File: rtl/sdes_decrypt_seq.sv
// Sequential S-DES decryptor: one shared fK stage run with K2 then K1.
// Accept -> RND1 -> RND2 -> DONE; out_valid is held in DONE until out_ready.
module sdes_decrypt_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] key,
  input  logic [7:0] cipher,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] plaintext,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [1:0] {S_IDLE, S_RND1, S_RND2, S_DONE} state_t;

  // S-box tables packed as 16 x 2-bit entries, index = {row, col}
  localparam logic [31:0] S0_TAB = {2'd2, 2'd3, 2'd1, 2'd3, 2'd3, 2'd1, 2'd2, 2'd0,
                                    2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd0, 2'd1};
  localparam logic [31:0] S1_TAB = {2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd3,
                                    2'd3, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};

  function automatic logic [1:0] sbox(input logic [31:0] tab, input logic [3:0] n);
    logic [4:0] idx;
    idx = {n[3], n[0], n[2], n[1], 1'b0};
    return tab[idx +: 2];
  endfunction

  function automatic logic [7:0] fk(input logic [3:0] l, input logic [3:0] r,
                                    input logic [7:0] k);
    logic [7:0] e;
    logic [3:0] s;
    e = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ k;
    s = {sbox(S0_TAB, e[7:4]), sbox(S1_TAB, e[3:0])};
    return {l ^ {s[2], s[0], s[1], s[3]}, r};
  endfunction

  state_t     r_state, w_state_nxt;
  logic [3:0] r_l, r_r, w_l_nxt, w_r_nxt;
  logic [7:0] r_k1, r_k2, w_k1_nxt, w_k2_nxt;
  logic [7:0] r_pt, w_pt_nxt;
  logic       r_ov, w_ov_nxt;

  logic [7:0] w_ip, w_k1_in, w_k2_in, w_rkey, w_f, w_ipinv;

  assign w_ip    = {cipher[6], cipher[2], cipher[5], cipher[7],
                    cipher[4], cipher[0], cipher[3], cipher[1]};
  assign w_k1_in = {key[9], key[3], key[1], key[6], key[2], key[7], key[0], key[4]};
  assign w_k2_in = {key[2], key[7], key[4], key[5], key[0], key[8], key[1], key[9]};

  // Decryption applies the subkeys in reverse order: K2 in RND1, K1 in RND2
  assign w_rkey  = (r_state == S_RND1) ? r_k2 : r_k1;
  assign w_f     = fk(r_l, r_r, w_rkey);
  assign w_ipinv = {w_f[4], w_f[7], w_f[5], w_f[3], w_f[1], w_f[6], w_f[0], w_f[2]};

  assign in_ready  = (r_state == S_IDLE);
  assign plaintext = r_pt;
  assign out_valid = r_ov;

  always_comb begin
    w_state_nxt = r_state;
    w_l_nxt     = r_l;
    w_r_nxt     = r_r;
    w_k1_nxt    = r_k1;
    w_k2_nxt    = r_k2;
    w_pt_nxt    = r_pt;
    w_ov_nxt    = r_ov;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_l_nxt     = w_ip[7:4];
          w_r_nxt     = w_ip[3:0];
          w_k1_nxt    = w_k1_in;
          w_k2_nxt    = w_k2_in;
          w_state_nxt = S_RND1;
        end
      end
      S_RND1: begin
        w_l_nxt     = r_r;
        w_r_nxt     = w_f[7:4];
        w_state_nxt = S_RND2;
      end
      S_RND2: begin
        w_pt_nxt    = w_ipinv;
        w_ov_nxt    = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          w_ov_nxt    = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_ov_nxt    = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_l     <= 4'h0;
      r_r     <= 4'h0;
      r_k1    <= 8'h00;
      r_k2    <= 8'h00;
      r_pt    <= 8'h00;
      r_ov    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_l     <= w_l_nxt;
      r_r     <= w_r_nxt;
      r_k1    <= w_k1_nxt;
      r_k2    <= w_k2_nxt;
      r_pt    <= w_pt_nxt;
      r_ov    <= w_ov_nxt;
    end
  end

endmodule

// File: tb/tb_sdes_decrypt_seq.sv
// Bench for sdes_decrypt_seq: hand-computed vectors, encrypt/decrypt round trip,
// backpressure, busy drop, input isolation and asynchronous reset mid-operation.
module tb_sdes_decrypt_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] key;
  logic [7:0] cipher;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] plaintext;
  logic       out_valid;
  logic       out_ready;

  int n_cmp = 0;
  int n_err = 0;

  sdes_decrypt_seq dut (
    .clk(clk), .rst_n(rst_n), .key(key), .cipher(cipher), .in_valid(in_valid),
    .in_ready(in_ready), .plaintext(plaintext), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  int s0_t [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  int s1_t [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  function automatic logic [3:0] f_func(input logic [3:0] r, input logic [7:0] k);
    logic [7:0] e;
    logic [1:0] a, b;
    logic [3:0] i;
    int va, vb;
    e  = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ k;
    va = s0_t[{e[7], e[4]}][{e[6], e[5]}];
    vb = s1_t[{e[3], e[0]}][{e[2], e[1]}];
    a  = va[1:0];
    b  = vb[1:0];
    i  = {a, b};
    return {i[2], i[0], i[1], i[3]};
  endfunction

  // Reference encryptor: IP, fK(K1), SW, fK(K2), IP inverse
  function automatic logic [7:0] encrypt(input logic [7:0] p, input logic [9:0] k);
    logic [7:0] k1, k2, ip, x;
    logic [3:0] l, r, t;
    k1 = {k[9], k[3], k[1], k[6], k[2], k[7], k[0], k[4]};
    k2 = {k[2], k[7], k[4], k[5], k[0], k[8], k[1], k[9]};
    ip = {p[6], p[2], p[5], p[7], p[4], p[0], p[3], p[1]};
    l  = ip[7:4];
    r  = ip[3:0];
    l  = l ^ f_func(r, k1);
    t  = l; l = r; r = t;
    l  = l ^ f_func(r, k2);
    x  = {l, r};
    return {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic accept(input logic [7:0] c, input logic [9:0] k);
    int n;
    n = 0;
    cipher   = c;
    key      = k;
    in_valid = 1'b1;
    while (!in_ready && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(output logic [7:0] pt);
    check("lat_t0_out_valid", 32'(out_valid), 32'd0);
    check("lat_t0_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("lat_t1_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_t2_out_valid", 32'(out_valid), 32'd1);
    pt = plaintext;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_ack_out_valid", 32'(out_valid), 32'd0);
    check("post_ack_in_ready", 32'(in_ready), 32'd1);
  endtask

  typedef struct {
    logic [7:0] c;
    logic [9:0] k;
    logic [7:0] p;
  } vec_t;

  vec_t tbl [4];

  initial begin
    logic [7:0] pt, p, c, held;
    logic [9:0] k;

    tbl[0] = '{c: 8'hF0, k: 10'h000, p: 8'h00};
    tbl[1] = '{c: 8'h38, k: 10'h282, p: 8'h97};
    tbl[2] = '{c: 8'hEB, k: 10'h3FF, p: 8'h00};
    tbl[3] = '{c: 8'h14, k: 10'h000, p: 8'hFF};

    rst_n = 1'b0; key = '0; cipher = '0; in_valid = 1'b0; out_ready = 1'b0;
    #2;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_plaintext", 32'(plaintext), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 4; i++) begin
      accept(tbl[i].c, tbl[i].k);
      collect(pt);
      check($sformatf("vec%0d_plaintext", i), 32'(pt), 32'(tbl[i].p));
    end

    // Round trip through the reference encryptor
    for (int i = 0; i < 500; i++) begin
      p = 8'($urandom_range(0, 255));
      k = 10'($urandom_range(0, 1023));
      accept(encrypt(p, k), k);
      collect(pt);
      check($sformatf("roundtrip%0d k=%0h", i, k), 32'(pt), 32'(p));
    end

    // Backpressure in DONE
    accept(8'h38, 10'h282);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_plaintext", 32'(plaintext), 32'h97);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);

    // Busy drop: second block offered while busy is only taken in IDLE
    accept(8'h38, 10'h282);
    cipher = 8'hF0; key = 10'h000; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("busy_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    check("busy_out_valid", 32'(out_valid), 32'd1);
    check("busy_first_plaintext", 32'(plaintext), 32'h97);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("busy_idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect(pt);
    check("busy_second_plaintext", 32'(pt), 32'h00);

    // Input isolation: key and cipher scrambled after accept
    p = 8'h5A;
    k = 10'h1C3;
    c = encrypt(p, k);
    accept(c, k);
    for (int i = 0; i < 2; i++) begin
      cipher = 8'($urandom_range(0, 255));
      key    = 10'($urandom_range(0, 1023));
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("iso_out_valid", 32'(out_valid), 32'd1);
    check("iso_plaintext", 32'(plaintext), 32'(p));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous reset in RND2: previous result must be wiped
    accept(8'h38, 10'h282);
    collect(pt);
    check("pre_reset_plaintext", 32'(pt), 32'h97);
    accept(8'h14, 10'h000);
    @(posedge clk); #1;
    held = plaintext;
    check("rnd2_plaintext_held", 32'(held), 32'h97);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_rnd2_out_valid", 32'(out_valid), 32'd0);
    check("rst_rnd2_in_ready", 32'(in_ready), 32'd1);
    check("rst_rnd2_plaintext", 32'(plaintext), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_stale_valid", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset in DONE
    accept(8'h38, 10'h282);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("done_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_done_out_valid", 32'(out_valid), 32'd0);
    check("rst_done_plaintext", 32'(plaintext), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;

    accept(8'hF0, 10'h000);
    collect(pt);
    check("post_rst_block", 32'(pt), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
